layer_stream_serializer: RTL and testbench

Parametrised, double-buffered serializer between neural-network layers. It captures a layer's parallel output vector of NUM_WORDS neuron values in one cycle and streams it out one word per cycle to the next layer or to the AXI read path. The downstream side has a valid/ready handshake with backpressure. A second buffer lets the next vector be captured while the current one is still draining. An optional running argmax yields the classification result at the end of each vector.

---
 rtl/nn_pkg.sv | 17 +
 rtl/layer_stream_serializer_if.sv | 42 ++++
 rtl/layer_stream_serializer_argmax_tracker.sv | 63 ++++++
 rtl/layer_stream_serializer.sv | 116 +++++++++++
 tb/tb_layer_stream_serializer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// Shared constants, sender state encoding and index-width helper for the layer serializer slice.
package nn_pkg;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefNumWords  = 30;

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } ser_state_e;

  // Never returns zero so a one-word index still has a legal width.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/layer_stream_serializer_if.sv
// Capture and stream-out handshake bundle of the layer serializer.
// Argmax result signals exist only when SER_ARGMAX_EN is defined.
interface layer_stream_serializer_if
  import nn_pkg::*;
#(
  parameter int unsigned NUM_WORDS  = DefNumWords,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned IDX_WIDTH  = idx_width(NUM_WORDS)
);

  logic [NUM_WORDS*DATA_WIDTH-1:0] in_data;
  logic                            in_valid;
  logic                            in_ready;
  logic [DATA_WIDTH-1:0]           out_data;
  logic                            out_valid;
  logic                            out_ready;
  logic                            out_last;
  logic [IDX_WIDTH-1:0]            out_index;
  logic                            drop;
`ifdef SER_ARGMAX_EN
  logic [IDX_WIDTH-1:0]            argmax_index;
  logic [DATA_WIDTH-1:0]           argmax_data;
  logic                            argmax_valid;
`endif

  modport master (
    output in_data, in_valid, out_ready,
`ifdef SER_ARGMAX_EN
    input  argmax_index, argmax_data, argmax_valid,
`endif
    input  in_ready, out_data, out_valid, out_last, out_index, drop
  );

  modport slave (
    input  in_data, in_valid, out_ready,
`ifdef SER_ARGMAX_EN
    output argmax_index, argmax_data, argmax_valid,
`endif
    output in_ready, out_data, out_valid, out_last, out_index, drop
  );

endinterface

// File: rtl/layer_stream_serializer_argmax_tracker.sv
// Running signed maximum over one streamed vector; publishes index/value one cycle after the
// last-word handshake. Only instantiated when SER_ARGMAX_EN is defined.
module argmax_tracker
  import nn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned IDX_WIDTH  = idx_width(DefNumWords)
) (
  input  logic                  s_axi_aclk,
  input  logic                  reset,
  input  logic                  hs_i,
  input  logic                  last_i,
  input  logic [IDX_WIDTH-1:0]  index_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [IDX_WIDTH-1:0]  argmax_index_o,
  output logic [DATA_WIDTH-1:0] argmax_data_o,
  output logic                  argmax_valid_o
);

  logic [DATA_WIDTH-1:0] max_q, max_d, res_data_q, res_data_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d, res_idx_q, res_idx_d;
  logic                  valid_q, valid_d;
  logic                  is_new;

  always_comb begin
    // Strict greater-than keeps the lower index on ties; word 0 always seeds the maximum.
    is_new     = (index_i == '0) || ($signed(data_i) > $signed(max_q));
    max_d      = max_q;
    idx_d      = idx_q;
    res_data_d = res_data_q;
    res_idx_d  = res_idx_q;
    valid_d    = hs_i && last_i;
    if (hs_i && is_new) begin
      max_d = data_i;
      idx_d = index_i;
    end
    if (hs_i && last_i) begin
      res_data_d = max_d;
      res_idx_d  = idx_d;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      max_q      <= '0;
      idx_q      <= '0;
      res_data_q <= '0;
      res_idx_q  <= '0;
      valid_q    <= 1'b0;
    end else begin
      max_q      <= max_d;
      idx_q      <= idx_d;
      res_data_q <= res_data_d;
      res_idx_q  <= res_idx_d;
      valid_q    <= valid_d;
    end
  end

  assign argmax_index_o = res_idx_q;
  assign argmax_data_o  = res_data_q;
  assign argmax_valid_o = valid_q;

endmodule

// File: rtl/layer_stream_serializer.sv
// Double-buffered parallel-to-serial converter between NN layers with valid/ready output.
// Define SER_ARGMAX_EN to add the running argmax classifier on the output stream.
module layer_stream_serializer
  import nn_pkg::*;
#(
  parameter int unsigned NUM_WORDS  = DefNumWords,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned IDX_WIDTH  = idx_width(NUM_WORDS)
) (
  input logic                      s_axi_aclk,
  input logic                      reset,
  layer_stream_serializer_if.slave bus
);

  localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NUM_WORDS - 1);

  logic [DATA_WIDTH-1:0] slot_q [2][NUM_WORDS];
  ser_state_e            state_q, state_d;
  logic [IDX_WIDTH-1:0]  cnt_q, cnt_d;
  logic [1:0]            occ_q, occ_d;
  logic                  wr_ptr_q, rd_ptr_q;
  logic                  cap, free, hs;
  logic [DATA_WIDTH-1:0] word;

  assign cap  = bus.in_valid && (occ_q < 2'd2);
  assign hs   = (state_q == StSend) && bus.out_ready;
  assign word = slot_q[rd_ptr_q][cnt_q];

  // Capture only ever targets a free slot, so the draining slot stays stable under backpressure.
  always_ff @(posedge s_axi_aclk) begin
    if (cap) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        slot_q[wr_ptr_q][k] <= bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      occ_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_q ^ cap;
      rd_ptr_q <= rd_ptr_q ^ free;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    free    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (occ_q != 2'd0) begin
          state_d = StSend;
          cnt_d   = '0;
        end
      end
      StSend: begin
        if (hs) begin
          if (cnt_q == LastIdx) begin
            free  = 1'b1;
            cnt_d = '0;
            // A vector landing this very cycle also counts, so back-to-back has no bubble.
            if (!(occ_q == 2'd2 || cap)) state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    unique case ({cap, free})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    bus.in_ready  = (occ_q < 2'd2);
    bus.drop      = bus.in_valid && (occ_q == 2'd2);
    bus.out_valid = (state_q == StSend);
    bus.out_data  = (state_q == StSend) ? word : '0;
    bus.out_index = cnt_q;
    bus.out_last  = (state_q == StSend) && (cnt_q == LastIdx);
  end

`ifdef SER_ARGMAX_EN
  argmax_tracker #(
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_argmax (
    .s_axi_aclk    (s_axi_aclk),
    .reset         (reset),
    .hs_i          (hs),
    .last_i        (cnt_q == LastIdx),
    .index_i       (cnt_q),
    .data_i        (word),
    .argmax_index_o(bus.argmax_index),
    .argmax_data_o (bus.argmax_data),
    .argmax_valid_o(bus.argmax_valid)
  );
`endif

endmodule

// File: tb/tb_layer_stream_serializer.sv
// Directed self-checking bench for layer_stream_serializer with NUM_WORDS=4, DATA_WIDTH=16.
module tb_layer_stream_serializer;

  localparam int unsigned NW = 4;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  layer_stream_serializer_if #(.NUM_WORDS(NW), .DATA_WIDTH(DW), .IDX_WIDTH(2)) bus ();

  layer_stream_serializer #(
    .NUM_WORDS (NW),
    .DATA_WIDTH(DW),
    .IDX_WIDTH (2)
  ) dut (
    .s_axi_aclk(clk),
    .reset     (rst),
    .bus       (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input logic [15:0] w0, w1, w2, w3);
    bus.in_data  = {w3, w2, w1, w0};
    bus.in_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.drop !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got v=%b l=%b d=%b want 0 0 0", bus.out_valid, bus.out_last, bus.drop);
    end
    n_checks++;
    if (bus.out_index !== 2'd0 || bus.out_data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_out got idx=%0d data=%h want 0 0000", bus.out_index, bus.out_data);
    end
`ifdef SER_ARGMAX_EN
    n_checks++;
    if (bus.argmax_valid !== 1'b0 || bus.argmax_index !== 2'd0 || bus.argmax_data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_argmax got v=%b idx=%0d data=%h want 0 0 0000",
               bus.argmax_valid, bus.argmax_index, bus.argmax_data);
    end
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [15:0] exp [4];
    exp = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    bus.out_ready = 1'b1;
    drive_vec(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency got valid=%b want 0", bus.out_valid); end
    step();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp[i] || bus.out_index !== 2'(i) ||
          bus.out_last !== (i == 3)) begin
        n_fail++;
        $display("FAIL single_word%0d got v=%b d=%h idx=%0d l=%b want 1 %h %0d %b", i,
                 bus.out_valid, bus.out_data, bus.out_index, bus.out_last, exp[i], i, (i == 3));
      end
      step();
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_end got valid=%b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp [4];
    int k;
    exp = '{16'h0005, 16'h0006, 16'h0007, 16'h0008};
    k = 0;
    bus.out_ready = 1'b0;
    drive_vec(16'h0005, 16'h0006, 16'h0007, 16'h0008);
    step();
    bus.in_valid = 1'b0;
    step();
    for (int c = 0; c < 16 && k < 4; c++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp[k] || bus.out_index !== 2'(k)) begin
        n_fail++;
        $display("FAIL bp_cycle%0d got v=%b d=%h idx=%0d want 1 %h %0d", c, bus.out_valid,
                 bus.out_data, bus.out_index, exp[k], k);
      end
      bus.out_ready = (c % 2 == 0);
      if (bus.out_ready) k++;
      step();
    end
    n_checks++;
    if (bus.out_valid !== 1'b0 || k !== 4) begin
      n_fail++;
      $display("FAIL bp_end got valid=%b words=%0d want 0 4", bus.out_valid, k);
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp [8];
    exp = '{16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0021, 16'h0022, 16'h0023, 16'h0024};
    bus.out_ready = 1'b1;
    drive_vec(16'h0011, 16'h0012, 16'h0013, 16'h0014);
    step();
    drive_vec(16'h0021, 16'h0022, 16'h0023, 16'h0024);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp[i]) begin
        n_fail++;
        $display("FAIL b2b_word%0d got v=%b d=%h want 1 %h", i, bus.out_valid, bus.out_data, exp[i]);
      end
      step();
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got valid=%b want 0", bus.out_valid); end
  endtask

  task automatic test_drop();
    logic [15:0] exp [8];
    int drops;
    exp = '{16'h0031, 16'h0032, 16'h0033, 16'h0034, 16'h0041, 16'h0042, 16'h0043, 16'h0044};
    drops = 0;
    bus.out_ready = 1'b0;
    drive_vec(16'h0031, 16'h0032, 16'h0033, 16'h0034);
    step();
    drive_vec(16'h0041, 16'h0042, 16'h0043, 16'h0044);
    step();
    bus.in_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL drop_full got in_ready=%b want 0", bus.in_ready); end
    drive_vec(16'h0051, 16'h0052, 16'h0053, 16'h0054);
    #1;
    if (bus.drop === 1'b1) drops++;
    step();
    bus.in_valid = 1'b0;
    #1;
    if (bus.drop === 1'b1) drops++;
    n_checks++;
    if (drops !== 1) begin n_fail++; $display("FAIL drop_pulse got %0d pulses want 1", drops); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp[i]) begin
        n_fail++;
        $display("FAIL drop_word%0d got v=%b d=%h want 1 %h", i, bus.out_valid, bus.out_data, exp[i]);
      end
      step();
    end
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drop_extra got valid=%b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp [4];
    exp = '{16'h0061, 16'h0062, 16'h0063, 16'h0064};
    bus.out_ready = 1'b1;
    drive_vec(16'h0071, 16'h0072, 16'h0073, 16'h0074);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    n_checks++;
    if (bus.out_data !== 16'h0072) begin n_fail++; $display("FAIL rstmid_pre got d=%h want 0072", bus.out_data); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_index !== 2'd0) begin
      n_fail++;
      $display("FAIL rstmid_state got v=%b rdy=%b idx=%0d want 0 1 0", bus.out_valid, bus.in_ready,
               bus.out_index);
    end
    drive_vec(16'h0061, 16'h0062, 16'h0063, 16'h0064);
    step();
    bus.in_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp[i] || bus.out_index !== 2'(i)) begin
        n_fail++;
        $display("FAIL rstmid_word%0d got v=%b d=%h idx=%0d want 1 %h %0d", i, bus.out_valid,
                 bus.out_data, bus.out_index, exp[i], i);
      end
      step();
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_end got valid=%b want 0", bus.out_valid); end
  endtask

`ifdef SER_ARGMAX_EN
  task automatic test_argmax();
    bus.out_ready = 1'b1;
    drive_vec(16'hFFFE, 16'h0005, 16'h0005, 16'h0003);
    step();
    bus.in_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.argmax_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL argmax_early%0d got valid=%b want 0", i, bus.argmax_valid);
      end
      step();
    end
    n_checks++;
    if (bus.argmax_valid !== 1'b1 || bus.argmax_index !== 2'd1 || bus.argmax_data !== 16'h0005) begin
      n_fail++;
      $display("FAIL argmax_result got v=%b idx=%0d d=%h want 1 1 0005", bus.argmax_valid,
               bus.argmax_index, bus.argmax_data);
    end
    step();
    n_checks++;
    if (bus.argmax_valid !== 1'b0 || bus.argmax_index !== 2'd1 || bus.argmax_data !== 16'h0005) begin
      n_fail++;
      $display("FAIL argmax_hold got v=%b idx=%0d d=%h want 0 1 0005", bus.argmax_valid,
               bus.argmax_index, bus.argmax_data);
    end
  endtask
`endif

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_drop();
    test_reset_mid();
`ifdef SER_ARGMAX_EN
    test_argmax();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
